serpent_key_schedule: RTL and testbench

- Serpent key expansion stage. Sits directly upstream of the 32-round encryption pipeline and drives its packed 33-subkey bus.
- Accepts a user key of 256 bits or fewer and iterates the affine prekey recurrence.
- Applies the bitslice S-boxes and produces one 128-bit round key per clock.
- Holds the complete 4224-bit key bus stable, with a valid flag, until the next key load.

---
 rtl/serpent_key_schedule.sv | 144 ++++++++++++++
 tb/tb_serpent_key_schedule.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serpent_key_schedule.sv
// Serpent key expansion: pads the user key, runs the affine prekey recurrence
// four words per cycle and writes one bitslice round key per clock.
module serpent_key_schedule (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [255:0]  key_in,
  input  logic [8:0]    key_len,
  output logic          busy,
  output logic          keys_valid,
  output logic [4223:0] keys
);

  localparam logic [31:0] PHI        = 32'h9E3779B9;
  localparam int unsigned NROUNDKEYS = 33;
  localparam int unsigned KEYW       = 128;
  localparam int unsigned LAST       = NROUNDKEYS - 1;

  // Nibble n of each row sits at bits [63-4n -: 4] (entry 0 is the top nibble).
  localparam logic [63:0] SBOX [8] = '{
    64'h38F1A65BED42709C,
    64'hFC27905A1BE86D34,
    64'h86793CAFD1E40B52,
    64'h0FB8C963D124A75E,
    64'h1F83C0B6254A9E7D,
    64'hF52B4A9C03E8D671,
    64'h72C5846BE91FD3A0,
    64'h1DF0E82B74CA9356
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

  state_e              state_q, state_d;
  logic [7:0][31:0]    win_q, win_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [4223:0]       keys_q, keys_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;

  logic [8:0]          eff_len;
  logic [255:0]        padded;
  logic [11:0][31:0]   ext;
  logic [31:0]         pre;
  logic [2:0]          sel;
  logic [63:0]         row;
  logic [3:0]          nib;
  logic [3:0]          sout;
  logic [3:0][31:0]    y;
  logic [127:0]        rk;

  // Key padding: keep key_len bits, set the next bit, clear the rest.
  always_comb begin
    eff_len = ((key_len == 9'd0) || (key_len > 9'd256)) ? 9'd256 : key_len;
    padded  = '0;
    for (int unsigned b = 0; b < 256; b++) begin
      if (9'(b) < eff_len) padded[b] = key_in[b];
      else                 padded[b] = (9'(b) == eff_len);
    end
  end

  // Four chained prekeys; ext[0..7] is w(4j-8..4j-1), ext[8..11] is w(4j..4j+3).
  always_comb begin
    ext = '0;
    pre = '0;
    for (int unsigned k = 0; k < 8; k++) ext[k] = win_q[k];
    for (int unsigned k = 0; k < 4; k++) begin
      pre        = ext[k] ^ ext[k+3] ^ ext[k+5] ^ ext[k+7] ^ PHI ^ 32'({cnt_q, 2'(k)});
      ext[k + 8] = {pre[20:0], pre[31:21]};
    end
  end

  // Bitslice S-box over the four fresh prekeys.
  always_comb begin
    sel  = 3'd3 - cnt_q[2:0];
    row  = SBOX[sel];
    y    = '0;
    nib  = '0;
    sout = '0;
    for (int unsigned b = 0; b < 32; b++) begin
      nib  = {ext[11][b], ext[10][b], ext[9][b], ext[8][b]};
      sout = row[{~nib, 2'b00} +: 4];
      for (int unsigned q = 0; q < 4; q++) y[q][b] = sout[q];
    end
    rk = {y[3], y[2], y[1], y[0]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    keys_d  = keys_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = EXPAND;
          win_d   = padded;
          cnt_d   = '0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      EXPAND: begin
        for (int unsigned k = 0; k < 8; k++) win_d[k] = ext[k + 4];
        for (int unsigned s = 0; s < NROUNDKEYS; s++) begin
          if (cnt_q == 6'(s)) keys_d[(LAST - s) * KEYW +: KEYW] = rk;
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(LAST)) begin
          state_d = DONE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      keys_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      keys_q  <= keys_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy       = busy_q;
  assign keys_valid = valid_q;
  assign keys       = keys_q;

endmodule

// File: tb/tb_serpent_key_schedule.sv
// Self-checking bench for serpent_key_schedule against a flat-array model of
// the Serpent prekey recurrence and S-box tables.
module tb_serpent_key_schedule;

  localparam logic [31:0] PHI = 32'h9E3779B9;

  logic          clk;
  logic          rst;
  logic          start;
  logic [255:0]  key_in;
  logic [8:0]    key_len;
  logic          busy;
  logic          keys_valid;
  logic [4223:0] keys;

  int total = 0;
  int bad   = 0;

  logic [31:0]  mw [140];
  logic [127:0] exp_k [33];

  int SB [8][16] = '{
    '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
    '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
    '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
    '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
    '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
    '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
    '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
    '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
  };

  serpent_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .key_len    (key_len),
    .busy       (busy),
    .keys_valid (keys_valid),
    .keys       (keys)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [255:0] pad_model(input logic [255:0] k, input int len);
    int l;
    logic [255:0] one;
    l   = (len == 0 || len > 256) ? 256 : len;
    one = 256'd1;
    if (l == 256) return k;
    return (k & ((one << l) - one)) | (one << l);
  endfunction

  // mw[m] holds prekey w(m-8); exp_k[j] is round key j in bitslice form.
  task automatic model(input logic [255:0] p);
    logic [31:0] t;
    logic [31:0] y0, y1, y2, y3;
    int s, n, o;
    for (int m = 0; m < 8; m++) mw[m] = p[32*m +: 32];
    for (int m = 8; m < 140; m++) begin
      t     = mw[m-8] ^ mw[m-5] ^ mw[m-3] ^ mw[m-1] ^ PHI ^ 32'(m - 8);
      mw[m] = (t << 11) | (t >> 21);
    end
    for (int j = 0; j < 33; j++) begin
      s = (35 - j) % 8;
      for (int b = 0; b < 32; b++) begin
        n = int'(mw[4*j+8][b]) + 2 * int'(mw[4*j+9][b]) +
            4 * int'(mw[4*j+10][b]) + 8 * int'(mw[4*j+11][b]);
        o = SB[s][n];
        y0[b] = o[0];
        y1[b] = o[1];
        y2[b] = o[2];
        y3[b] = o[3];
      end
      exp_k[j] = {y3, y2, y1, y0};
    end
  endtask

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_keys(input string tag);
    for (int j = 0; j < 33; j++)
      check($sformatf("%s k%0d", tag, j), 256'(keys[4223 - 128*j -: 128]), 256'(exp_k[j]));
  endtask

  // Load a key, optionally pulse start mid-run, and check latency and keys.
  task automatic run_key(input logic [255:0] k, input int len, input bit pulses, input string tag);
    int n;
    model(pad_model(k, len));
    key_in  = k;
    key_len = 9'(len);
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check({tag, " busy_after_start"}, 256'(busy), 256'(1));
    check({tag, " valid_after_start"}, 256'(keys_valid), 256'(0));
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (pulses && (n == 5 || n == 20)) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    check({tag, " busy_cycles"}, 256'(n), 256'(33));
    check({tag, " valid_done"}, 256'(keys_valid), 256'(1));
    check_keys(tag);
  endtask

  initial begin
    logic [255:0] k;
    rst     = 1'b1;
    start   = 1'b0;
    key_in  = '0;
    key_len = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 256'(busy), 256'(0));
    check("reset valid", 256'(keys_valid), 256'(0));
    check("reset keys_nonzero", 256'(keys != '0), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    run_key('0, 256, 1'b0, "zero256");
    check("model w0", 256'(mw[8]), 256'(32'hBBCDCCF1));

    k = rand256();
    k[127:0] = '0;
    check("pad128 w-4", 256'(pad_model(k, 128)), 256'(1) << 128);
    run_key(k, 128, 1'b0, "zero128");

    run_key(rand256(), int'($urandom_range(1, 256)), 1'b1, "pulsed");

    // Abort mid-expansion with an asynchronous reset.
    key_in  = rand256();
    key_len = 9'd256;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (16) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst keys_nonzero", 256'(keys != '0), 256'(0));
    check("midrst busy", 256'(busy), 256'(0));
    check("midrst valid", 256'(keys_valid), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    run_key(rand256(), 256, 1'b0, "after_rst");

    run_key(rand256(), int'($urandom_range(1, 255)), 1'b0, "reload");

    k = rand256();
    k[0] = 1'b1;
    check("pad len1", pad_model(k, 1), 256'h3);
    run_key(k, 1, 1'b0, "len1");

    run_key(rand256(), 0, 1'b0, "len0");
    run_key(rand256(), 300, 1'b0, "len300");
    run_key(rand256(), 255, 1'b0, "len255");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
